// File: rtl/reg_file.sv
// Sixteen-entry register file: change-qualified request/ack interface for
// writes and single reads, plus two registered operand ports with write forwarding.
module reg_file #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic                 tclk,
    input  logic                 rst,
    input  logic                 reg_on,
    input  logic                 reg_w,
    input  logic [ADDR_W-1:0]    reg_addr,
    input  logic [WORD_SIZE-1:0] reg_data_in,
    output logic [WORD_SIZE-1:0] reg_data_out,
    output logic                 reg_ack,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr_a,
    input  logic [ADDR_W-1:0]    rd_addr_b,
    output logic [WORD_SIZE-1:0] rd_data_a,
    output logic [WORD_SIZE-1:0] rd_data_b,
    output logic                 rd_valid
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic                 w;
        logic [ADDR_W-1:0]    addr;
        logic [WORD_SIZE-1:0] data;
    } req_t;

    logic [WORD_SIZE-1:0] mem [NUM_REGS];

    req_t                 cur_req_c;
    req_t                 last_req;
    logic                 last_valid;
    logic                 accept_c;
    logic                 wr_c;
    logic                 rd_c;
    logic [WORD_SIZE-1:0] rd_word_c;
    logic [WORD_SIZE-1:0] fwd_a_c;
    logic [WORD_SIZE-1:0] fwd_b_c;

    // The driver holds reg_on high, so only a new tuple counts as a new request.
    always_comb begin
        cur_req_c = '{w: reg_w, addr: reg_addr, data: reg_data_in};
        accept_c  = reg_on && (!last_valid || (cur_req_c != last_req));
        wr_c      = accept_c && reg_w;
        rd_c      = accept_c && !reg_w;
    end

    // Operand values: r0 reads zero, a same-edge write is forwarded.
    always_comb begin
        rd_word_c = (reg_addr == '0) ? '0 : mem[reg_addr];

        if (rd_addr_a == '0) begin
            fwd_a_c = '0;
        end else if (wr_c && (reg_addr == rd_addr_a)) begin
            fwd_a_c = reg_data_in;
        end else begin
            fwd_a_c = mem[rd_addr_a];
        end

        if (rd_addr_b == '0) begin
            fwd_b_c = '0;
        end else if (wr_c && (reg_addr == rd_addr_b)) begin
            fwd_b_c = reg_data_in;
        end else begin
            fwd_b_c = mem[rd_addr_b];
        end
    end

    always_ff @(posedge tclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
            last_req     <= '0;
            last_valid   <= 1'b0;
            reg_ack      <= 1'b0;
            reg_data_out <= '0;
            rd_valid     <= 1'b0;
            rd_data_a    <= '0;
            rd_data_b    <= '0;
        end else begin
            reg_ack  <= accept_c;
            rd_valid <= rd_en;

            // Dropping reg_on re-arms acceptance of an identical tuple.
            if (!reg_on) begin
                last_valid <= 1'b0;
            end else if (accept_c) begin
                last_req   <= cur_req_c;
                last_valid <= 1'b1;
            end

            if (wr_c && (reg_addr != '0)) begin
                mem[reg_addr] <= reg_data_in;
            end

            if (rd_c) begin
                reg_data_out <= rd_word_c;
            end

            if (rd_en) begin
                rd_data_a <= fwd_a_c;
                rd_data_b <= fwd_b_c;
            end
        end
    end

endmodule

// File: doc/reg_file.md
# reg_file

Sixteen-entry general-purpose register file: the responder side of the register write interface (`reg_on`, `reg_w`, `reg_addr`, `reg_data_in`) driven by the ALU operand/writeback controller. It stores results, returns single-register reads on the same interface, and supplies two registered operand read ports with write-forwarding to feed the ALU operand inputs. Register 0 is hardwired to zero (MIPS convention).

## Interface
- `WORD_SIZE`, 32, data width of every register and data port
- `ADDR_W`, 4, register address width (16 registers; only `reg_addr[ADDR_W-1:0]` is used)

- `tclk` input 1: single clock, all state updates on rising edge
- `rst` input 1: reset, synchronous, active-high
- `reg_on` input 1: request enable (level; may be held high indefinitely)
- `reg_w` input 1: 1 = write request, 0 = read request
- `reg_addr` input ADDR_W: register index for the request
- `reg_data_in` input WORD_SIZE: write data
- `reg_data_out` output WORD_SIZE: read data for an accepted read request
- `reg_ack` output 1: one-cycle pulse per accepted request
- `rd_en` input 1: operand read strobe
- `rd_addr_a`, `rd_addr_b` input ADDR_W each: operand register indices
- `rd_data_a`, `rd_data_b` output WORD_SIZE each: operand data
- `rd_valid` output 1: one-cycle pulse, operand data valid

## Operation
- Reset (`rst`=1 at an edge): all 16 registers, `reg_data_out`, `rd_data_a`, `rd_data_b` -> 0; `reg_ack`, `rd_valid` -> 0; last-accepted tuple cleared and marked invalid. Reset overrides any request in the same cycle.
- Request acceptance (change-qualified, because the driver holds `reg_on` high):
  - A request is accepted at an edge when `reg_on`=1 AND (last tuple invalid OR `{reg_w, reg_addr, reg_data_in}` differs from the last accepted tuple).
  - On acceptance, the tuple is stored as the last accepted and marked valid. `reg_on`=0 at an edge marks it invalid, so the next high `reg_on` is accepted even with identical fields.
  - `reg_on`=1 with an unchanged tuple: no action, no ack.
- Accepted write: `mem[reg_addr] <= reg_data_in`. Address 0 is discarded (register 0 stays 0) but is still acknowledged.
- Accepted read: `reg_data_out <= mem[reg_addr]` (0 for address 0), using the pre-edge array contents. `reg_data_out` holds its value until the next accepted read or reset.
- Operand read (`rd_en`=1 at an edge):
  - `rd_data_x <= (addr==0) ? 0 : (accepted write this edge to same addr) ? reg_data_in : mem[addr]`.
  - The forward applies independently to port a and port b; both ports may name the same register.
  - Outputs hold until the next `rd_en` or reset.
- Operand reads and interface requests are independent and may occur at the same edge.

## Timing
- `reg_ack`: high exactly the one cycle after the accepting edge; back-to-back accepts give a continuously high `reg_ack`.
- Read latency: 1 cycle. `reg_data_out` is valid in the same cycle `reg_ack` is high.
- Write visibility:
  - Operand ports see a write at the same edge, through the forward.
  - The interface read port sees it from the next accepted read onward (a read cannot coincide with a write on the single interface).
- `rd_valid`: high the cycle after each `rd_en` edge; `rd_data_a/b` are valid alongside it.
- Reset mid-operation: a pending `reg_ack` or `rd_valid` is dropped. If `reg_on` is high while `rst` deasserts, the request is accepted at the first non-reset edge.

## Test plan
- Reset, then write 0xDEADBEEF to r5 with `reg_on` held high for 4 cycles -> exactly one `reg_ack` pulse; an interface read of r5 returns 0xDEADBEEF with `reg_ack` one cycle later.
- Write 0x12345678 to r0, then `rd_en` with a=0, b=0 -> `rd_data_a`=`rd_data_b`=0 and `rd_valid` pulses; the r0 write is still acked.
- Same edge: write 0xAAAA0001 to r3 and `rd_en` with a=3, b=4 (r4 = 0x44) -> next cycle `rd_data_a`=0xAAAA0001, `rd_data_b`=0x44.
- `reg_on` high writing 7 to r2, change `reg_data_in` to 9 while still high -> two acks, r2=9. Drop `reg_on` one cycle and re-raise with the same tuple -> third ack.
- Assert `rst` during the ack cycle of a write to r6 -> `reg_ack` is 0 next cycle, and r6, `reg_data_out`, `rd_data_a/b` all read 0.
- Sequential writes of distinct values to r1..r15, then `rd_en` over all pairs -> every readback matches; r0 = 0.
